// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path and the 68000 bus register decode.
// The bus decoder imports the same addresses so both sides agree on the register map.
package uart_rx_fifo_pkg;

  localparam int RX_FIFO_DEPTH_LOG2 = 4;
  localparam int UART_BYTE_W        = 8;

  // Word offsets within the UART register window
  localparam logic [3:0] BUS_ADDR_RX_DATA  = 4'h0;
  localparam logic [3:0] BUS_ADDR_RXF_STAT = 4'h2;
  localparam logic [3:0] BUS_ADDR_TX_STAT  = 4'h4;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO: simple dual-port RAM, synchronous write,
// registered read with enable so the output holds while the FIFO is empty.
module uart_rx_fifo_mem #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART byte strobe and the CPU RX data register; pops on the
// falling edge of rd_req. Optional rts_n hysteresis flow control under RX_FIFO_HWFLOW_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
  parameter int RTS_HI     = 12,
  parameter int RTS_LO     = 4
) (
  input  logic                  clk12,
  input  logic                  RSTn,
  input  logic                  wr_dv,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                  rd_req,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic                  rxf_n,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  rts_n
);

  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  if (RTS_LO >= RTS_HI || RTS_HI > (1 << DEPTH_LOG2)) begin : g_bad_rts_cfg
    $error("uart_rx_fifo: RTS_LO must be below RTS_HI and RTS_HI must not exceed the depth");
  end

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                rd_req_q;
  logic                rxf_n_q, rxf_n_d;
  logic                ovf_q, ovf_d;
  logic                empty, full, pop, push, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  // End of the bus read cycle; a long access still yields a single pop
  assign pop   = rd_req_q & ~rd_req & ~empty;
  assign push  = wr_dv & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_dv && full && !pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Status follows the read register: only bytes already in RAM count as readable,
  // so rxf_n and rd_data always move together.
  assign rxf_n_d = (wr_ptr_q == rd_ptr_d);
  assign rd_en   = ~rxf_n_d;

  always_ff @(posedge clk12) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_req_q <= 1'b0;
      rxf_n_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_req_q <= rd_req;
      rxf_n_q  <= rxf_n_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_rx_fifo_mem #(
    .AW (DEPTH_LOG2),
    .DW (UART_BYTE_W)
  ) u_mem (
    .clk_i   (clk12),
    .rst_n_i (RSTn),
    .we_i    (push & RSTn),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_d[DEPTH_LOG2-1:0]),
    .rdata_o (rd_data)
  );

  assign rxf_n = rxf_n_q;
  assign level = wr_ptr_q - rd_ptr_q;
  assign ovf   = ovf_q;

`ifdef RX_FIFO_HWFLOW_EN
  localparam logic [DEPTH_LOG2:0] RTS_HI_L = RTS_HI[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] RTS_LO_L = RTS_LO[DEPTH_LOG2:0];

  logic                rts_n_q, rts_n_d;
  logic [DEPTH_LOG2:0] level_d;

  assign level_d = wr_ptr_d - rd_ptr_d;

  always_comb begin
    rts_n_d = rts_n_q;
    if (level_d >= RTS_HI_L) begin
      rts_n_d = 1'b1;
    end else if (level_d <= RTS_LO_L) begin
      rts_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk12) begin
    if (!RSTn) begin
      rts_n_q <= 1'b0;
    end else begin
      rts_n_q <= rts_n_d;
    end
  end

  assign rts_n = rts_n_q;
`else
  assign rts_n = 1'b0;
`endif

endmodule
